// File: rtl/uart_word_framer.sv
// uart_word_framer: word/byte adapter between the debug controller and the UART core.
// TX slices an NBITS word into NBITS/DBITS bytes, sent LSB byte first, one handshake per byte.
// RX packs received bytes (LSB byte first) into a word and pulses w_rx_done.
// Optional macro WORD_FRAMER_RX_TIMEOUT_EN: drop a partial RX word after TIMEOUT_CYCLES idle clocks.
// Ports:
//   clk, reset            clock, async active-low reset
//   w_tx_data/start       word request from controller
//   w_tx_busy/done        word TX status (busy while sending, 1-cycle done)
//   w_rx_data/done        assembled word and 1-cycle update strobe
//   b_tx_data/start/done  byte handshake with the UART transmitter
//   b_rx_data/done        byte strobe from the UART receiver
//   rx_err                1-cycle pulse when a partial word times out
module uart_word_framer #(
   parameter int NBITS          = 32,
   parameter int DBITS          = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NBITS-1:0] w_tx_data,
   input  logic             w_tx_start,
   output logic             w_tx_busy,
   output logic             w_tx_done,
   output logic [NBITS-1:0] w_rx_data,
   output logic             w_rx_done,
   output logic [DBITS-1:0] b_tx_data,
   output logic             b_tx_start,
   input  logic             b_tx_done,
   input  logic [DBITS-1:0] b_rx_data,
   input  logic             b_rx_done,
   output logic             rx_err
);

   localparam int NBYTES = NBITS / DBITS;
   localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

   if ((NBITS % DBITS) != 0 || NBITS <= DBITS || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("uart_word_framer: illegal parameter set");
   end

   typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} tx_state_t;

   tx_state_t        state, state_nxt;
   logic [NBITS-1:0] tx_shift;
   logic [CW-1:0]    tx_cnt;
   logic             tx_accept;
   logic             tx_advance;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      tx_accept  = 1'b0;
      tx_advance = 1'b0;
      b_tx_start = 1'b0;
      w_tx_busy  = 1'b0;
      w_tx_done  = 1'b0;
      unique case (state)
         IDLE: begin
            if (w_tx_start) begin
               tx_accept = 1'b1;
               state_nxt = SEND;
            end
         end
         SEND: begin
            b_tx_start = 1'b1;
            w_tx_busy  = 1'b1;
            state_nxt  = WAIT;
         end
         WAIT: begin
            w_tx_busy = 1'b1;
            if (b_tx_done) begin
               if (tx_cnt == LAST) begin
                  state_nxt = DONE;
               end else begin
                  tx_advance = 1'b1;
                  state_nxt  = SEND;
               end
            end
         end
         DONE: begin
            w_tx_done = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_shift <= '0;
         tx_cnt   <= '0;
      end else if (tx_accept) begin
         tx_shift <= w_tx_data;
         tx_cnt   <= '0;
      end else if (tx_advance) begin
         tx_shift <= tx_shift >> DBITS;
         tx_cnt   <= tx_cnt + 1'b1;
      end
   end

   // The low byte stays put through WAIT because the shift only moves on b_tx_done.
   assign b_tx_data = tx_shift[DBITS-1:0];

   logic [NBITS-1:0] rx_shift;
   logic [NBITS-1:0] rx_next;
   logic [CW-1:0]    rx_cnt;
   logic             rx_expire;

   assign rx_next = {b_rx_data, rx_shift[NBITS-1:DBITS]};

`ifdef WORD_FRAMER_RX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] rx_timer;

   // A byte landing on the expiry cycle wins, so expiry is masked by b_rx_done.
   assign rx_expire = !b_rx_done && (rx_cnt != '0) && (rx_timer == TLAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_timer <= '0;
         rx_err   <= 1'b0;
      end else begin
         rx_err <= rx_expire;
         if (b_rx_done || rx_expire || rx_cnt == '0) rx_timer <= '0;
         else                                         rx_timer <= rx_timer + 1'b1;
      end
   end
`else
   assign rx_expire = 1'b0;
   assign rx_err    = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_shift  <= '0;
         rx_cnt    <= '0;
         w_rx_data <= '0;
         w_rx_done <= 1'b0;
      end else begin
         w_rx_done <= 1'b0;
         if (b_rx_done) begin
            rx_shift <= rx_next;
            if (rx_cnt == LAST) begin
               rx_cnt    <= '0;
               w_rx_data <= rx_next;
               w_rx_done <= 1'b1;
            end else begin
               rx_cnt <= rx_cnt + 1'b1;
            end
         end else if (rx_expire) begin
            rx_shift <= '0;
            rx_cnt   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_uart_word_framer.sv
// tb_uart_word_framer: directed bench for uart_word_framer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_word_framer;

   logic        clk;
   logic        reset;
   logic [31:0] w_tx_data;
   logic        w_tx_start;
   logic        w_tx_busy;
   logic        w_tx_done;
   logic [31:0] w_rx_data;
   logic        w_rx_done;
   logic [7:0]  b_tx_data;
   logic        b_tx_start;
   logic        b_tx_done;
   logic [7:0]  b_rx_data;
   logic        b_rx_done;
   logic        rx_err;

   int n_cmp = 0;
   int n_bad = 0;

   uart_word_framer #(
      .NBITS(32),
      .DBITS(8),
      .TIMEOUT_CYCLES(20)
   ) dut (
      .clk(clk),
      .reset(reset),
      .w_tx_data(w_tx_data),
      .w_tx_start(w_tx_start),
      .w_tx_busy(w_tx_busy),
      .w_tx_done(w_tx_done),
      .w_rx_data(w_rx_data),
      .w_rx_done(w_rx_done),
      .b_tx_data(b_tx_data),
      .b_tx_start(b_tx_start),
      .b_tx_done(b_tx_done),
      .b_rx_data(b_rx_data),
      .b_rx_done(b_rx_done),
      .rx_err(rx_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ts;
      logic [31:0] td;
      logic        btd;
      logic        brd;
      logic [7:0]  brdat;
      logic        e_bts;
      logic [7:0]  e_bdat;
      logic        e_busy;
      logic        e_wtd;
      logic        e_wrd;
      logic [31:0] e_wrdat;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(
      input logic ts, input logic [31:0] td, input logic btd,
      input logic brd, input logic [7:0] brdat,
      input logic e_bts, input logic [7:0] e_bdat, input logic e_busy,
      input logic e_wtd, input logic e_wrd, input logic [31:0] e_wrdat);
      vec_t v;
      v.ts = ts; v.td = td; v.btd = btd; v.brd = brd; v.brdat = brdat;
      v.e_bts = e_bts; v.e_bdat = e_bdat; v.e_busy = e_busy;
      v.e_wtd = e_wtd; v.e_wrd = e_wrd; v.e_wrdat = e_wrdat;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic rx_byte(input logic [7:0] b);
      b_rx_data = b;
      b_rx_done = 1'b1;
      tick();
      b_rx_done = 1'b0;
   endtask

   task automatic rx_word(input string nm, input logic [31:0] w);
      for (int i = 0; i < 4; i++) rx_byte(w[8*i +: 8]);
      chk({nm, " rx_done"}, w_rx_done, 1);
      chk({nm, " rx_data"}, w_rx_data, w);
      tick();
      chk({nm, " rx_done end"}, w_rx_done, 0);
   endtask

   task automatic run_table();
      // test 1: TX 0x10001000, byte done 3 cycles after each start
      add(1, 32'h10001000, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 32'h0);
      add(0, 0, 1, 0, 0, 1, 8'h00, 1, 0, 0, 32'h0);
      add(0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 32'h0);
      add(0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 32'h0);
      add(0, 0, 1, 0, 0, 0, 8'h00, 1, 0, 0, 32'h0);
      add(0, 0, 0, 0, 0, 1, 8'h10, 1, 0, 0, 32'h0);
      add(0, 0, 0, 0, 0, 0, 8'h10, 1, 0, 0, 32'h0);
      add(0, 0, 0, 0, 0, 0, 8'h10, 1, 0, 0, 32'h0);
      add(0, 0, 1, 0, 0, 0, 8'h10, 1, 0, 0, 32'h0);
      add(0, 0, 0, 0, 0, 1, 8'h00, 1, 0, 0, 32'h0);
      add(0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 32'h0);
      add(0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 32'h0);
      add(0, 0, 1, 0, 0, 0, 8'h00, 1, 0, 0, 32'h0);
      add(0, 0, 0, 0, 0, 1, 8'h10, 1, 0, 0, 32'h0);
      add(0, 0, 0, 0, 0, 0, 8'h10, 1, 0, 0, 32'h0);
      add(0, 0, 0, 0, 0, 0, 8'h10, 1, 0, 0, 32'h0);
      add(0, 0, 1, 0, 0, 0, 8'h10, 1, 0, 0, 32'h0);
      add(0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 0, 32'h0);
      add(0, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 32'h0);
      // test 2: RX words 0x000000FF then 0xFFFFFFFF back to back
      add(0, 0, 0, 1, 8'hFF, 0, 8'h00, 0, 0, 0, 32'h0);
      add(0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0, 0, 32'h0);
      add(0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0, 0, 32'h0);
      add(0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0, 0, 32'h0);
      add(0, 0, 0, 1, 8'hFF, 0, 8'h00, 0, 0, 1, 32'h000000FF);
      add(0, 0, 0, 1, 8'hFF, 0, 8'h00, 0, 0, 0, 32'h000000FF);
      add(0, 0, 0, 1, 8'hFF, 0, 8'h00, 0, 0, 0, 32'h000000FF);
      add(0, 0, 0, 1, 8'hFF, 0, 8'h00, 0, 0, 0, 32'h000000FF);
      add(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 32'hFFFFFFFF);
      add(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 32'hFFFFFFFF);

      for (int i = 0; i < tbl.size(); i++) begin
         chk($sformatf("vec%0d b_tx_start", i), b_tx_start, tbl[i].e_bts);
         chk($sformatf("vec%0d busy", i), w_tx_busy, tbl[i].e_busy);
         chk($sformatf("vec%0d w_tx_done", i), w_tx_done, tbl[i].e_wtd);
         chk($sformatf("vec%0d w_rx_done", i), w_rx_done, tbl[i].e_wrd);
         chk($sformatf("vec%0d w_rx_data", i), w_rx_data, tbl[i].e_wrdat);
         chk($sformatf("vec%0d rx_err", i), rx_err, 0);
         if (tbl[i].e_busy)
            chk($sformatf("vec%0d b_tx_data", i), b_tx_data, tbl[i].e_bdat);
         w_tx_start = tbl[i].ts;
         w_tx_data  = tbl[i].td;
         b_tx_done  = tbl[i].btd;
         b_rx_done  = tbl[i].brd;
         b_rx_data  = tbl[i].brdat;
         tick();
      end
      w_tx_start = 1'b0;
      b_tx_done  = 1'b0;
      b_rx_done  = 1'b0;
   endtask

   // Word send with a 3-cycle byte responder; optional ignored second
   // request and optional RX bytes aligned with each b_tx_done.
   task automatic run_tx(input string nm, input logic [31:0] w,
                         input bit inj, input logic [31:0] w2,
                         input bit rx_on, input logic [31:0] rxw);
      int nb, since, ndone, nrx, last_done, wtd_cyc;
      bit waiting, busy_bad;
      logic [31:0] got_rx;
      nb = 0; since = 0; ndone = 0; nrx = 0;
      last_done = -10; wtd_cyc = -1;
      waiting = 0; busy_bad = 0; got_rx = '0;
      w_tx_data = w;
      w_tx_start = 1'b1;
      tick();
      w_tx_start = 1'b0;
      for (int c = 1; c < 40; c++) begin
         if (ndone == 0 && !w_tx_done && !w_tx_busy) busy_bad = 1;
         if ((ndone > 0 || w_tx_done) && w_tx_busy) busy_bad = 1;
         if (b_tx_start) begin
            if (nb < 4) chk($sformatf("%s byte%0d", nm, nb), b_tx_data, w[8*nb +: 8]);
            nb++;
            since = 0;
            waiting = 1;
         end
         if (w_tx_done) begin
            ndone++;
            wtd_cyc = c;
         end
         if (w_rx_done) begin
            nrx++;
            got_rx = w_rx_data;
         end
         b_tx_done = 1'b0;
         b_rx_done = 1'b0;
         w_tx_start = 1'b0;
         if (waiting && since == 3) begin
            b_tx_done = 1'b1;
            waiting = 0;
            last_done = c;
            if (rx_on) begin
               b_rx_done = 1'b1;
               b_rx_data = rxw[8*(nb-1) +: 8];
            end
         end
         if (inj && nb == 2 && since == 1) begin
            w_tx_start = 1'b1;
            w_tx_data = w2;
         end
         since++;
         tick();
      end
      b_tx_done = 1'b0;
      b_rx_done = 1'b0;
      w_tx_start = 1'b0;
      chk({nm, " byte count"}, nb, 4);
      chk({nm, " done count"}, ndone, 1);
      chk({nm, " done latency"}, wtd_cyc, last_done + 1);
      chk({nm, " busy window"}, busy_bad, 0);
      if (rx_on) begin
         chk({nm, " rx count"}, nrx, 1);
         chk({nm, " rx word"}, got_rx, rxw);
      end
   endtask

   task automatic run_reset();
      bit q;
      w_tx_data = 32'hA1B2C3D4;
      w_tx_start = 1'b1;
      b_rx_data = 8'h55;
      b_rx_done = 1'b1;
      tick();
      w_tx_start = 1'b0;
      b_rx_data = 8'h66;
      tick();
      b_rx_done = 1'b0;
      tick();
      tick();
      b_tx_done = 1'b1;
      tick();
      b_tx_done = 1'b0;
      repeat (3) tick();
      b_tx_done = 1'b1;
      tick();
      b_tx_done = 1'b0;
      tick();
      chk("t5 busy before reset", w_tx_busy, 1);
      chk("t5 byte2 before reset", b_tx_data, 8'hB2);
      reset = 1'b0;
      #1;
      chk("t5 rst b_tx_start", b_tx_start, 0);
      chk("t5 rst b_tx_data", b_tx_data, 0);
      chk("t5 rst busy", w_tx_busy, 0);
      chk("t5 rst w_tx_done", w_tx_done, 0);
      chk("t5 rst w_rx_data", w_rx_data, 0);
      chk("t5 rst w_rx_done", w_rx_done, 0);
      chk("t5 rst rx_err", rx_err, 0);
      tick();
      reset = 1'b1;
      q = 0;
      for (int i = 0; i < 6; i++) begin
         if (w_tx_done || w_rx_done || w_tx_busy || b_tx_start) q = 1;
         tick();
      end
      chk("t5 quiet after reset", q, 0);
      rx_word("t5", 32'h04030201);
   endtask

   task automatic run_timeout();
      bit e;
`ifdef WORD_FRAMER_RX_TIMEOUT_EN
      rx_byte(8'h11);
      rx_byte(8'h22);
      e = 0;
      for (int i = 0; i < 20; i++) begin
         if (rx_err || w_rx_done) e = 1;
         tick();
      end
      chk("t6 early rx_err", e, 0);
      chk("t6 rx_err pulse", rx_err, 1);
      chk("t6 no rx_done", w_rx_done, 0);
      tick();
      chk("t6 rx_err width", rx_err, 0);
      rx_word("t6 after drop", 32'h0A0B0C0D);
      rx_byte(8'h0D);
      rx_byte(8'h0C);
      e = 0;
      for (int i = 0; i < 19; i++) begin
         if (rx_err) e = 1;
         tick();
      end
      rx_byte(8'h0B);
      if (rx_err) e = 1;
      rx_byte(8'h0A);
      chk("t6 edge no rx_err", e | rx_err, 0);
      chk("t6 edge rx_done", w_rx_done, 1);
      chk("t6 edge rx_data", w_rx_data, 32'h0A0B0C0D);
      tick();
`else
      rx_byte(8'h0D);
      rx_byte(8'h0C);
      e = 0;
      for (int i = 0; i < 40; i++) begin
         if (rx_err || w_rx_done) e = 1;
         tick();
      end
      chk("t6 no timeout", e, 0);
      rx_byte(8'h0B);
      rx_byte(8'h0A);
      chk("t6 late rx_done", w_rx_done, 1);
      chk("t6 late rx_data", w_rx_data, 32'h0A0B0C0D);
      tick();
`endif
   endtask

   initial begin
      reset = 1'b1;
      w_tx_data = '0;
      w_tx_start = 1'b0;
      b_tx_done = 1'b0;
      b_rx_data = '0;
      b_rx_done = 1'b0;
      #2 reset = 1'b0;
      tick();
      tick();
      chk("reset b_tx_start", b_tx_start, 0);
      chk("reset b_tx_data", b_tx_data, 0);
      chk("reset busy", w_tx_busy, 0);
      chk("reset w_tx_done", w_tx_done, 0);
      chk("reset w_rx_data", w_rx_data, 0);
      chk("reset w_rx_done", w_rx_done, 0);
      chk("reset rx_err", rx_err, 0);
      reset = 1'b1;
      tick();
      run_table();
      tick();
      run_tx("t3", 32'h45003000, 1, 32'h00000023, 0, 32'h0);
      run_tx("t4", 32'hFFFFFFFF, 0, 32'h0, 1, 32'h00000023);
      run_reset();
      run_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
